// File: rtl/digit_entry_pkg.sv
// Shared constants, FSM state type and BCD helpers for the digit entry block.
package digit_entry_pkg;

  localparam int DIGIT_W  = 4;
  localparam int DIGIT_N  = 4;
  localparam int SIGN_BIT = 16;
  localparam int DB_W     = SIGN_BIT + 1;

  localparam logic [2:0] CURSOR_MAX = 3'd4;

  typedef enum logic [0:0] {
    EDIT     = 1'b0,
    WAIT_ACK = 1'b1
  } state_e;

  // Modulo-10 increment; out-of-range input is folded to 0 so a digit never holds 10..15.
  function automatic logic [DIGIT_W-1:0] bcd_inc(input logic [DIGIT_W-1:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  // Modulo-10 decrement; out-of-range input is folded to 9.
  function automatic logic [DIGIT_W-1:0] bcd_dec(input logic [DIGIT_W-1:0] d);
    return (d == 4'd0 || d > 4'd9) ? 4'd9 : d - 4'd1;
  endfunction

endpackage

// File: rtl/digit_entry_button_debounce.sv
// Raw push-button conditioning: 2-flop synchronizer, stability debouncer
// built on a reloading down-counter, and a one-cycle press pulse on the
// debounced rising edge.
module button_debounce
  import digit_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic CLK,
  input  logic RST,
  input  logic btn,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  // Bring the asynchronous button into the CLK domain.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES
  // consecutive cycles; any return to the old level reloads the counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (sync2 == level) begin
      cnt <= RELOAD;
    end else if (cnt == '0) begin
      level <= sync2;
      cnt   <= RELOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  // Delayed copy of the debounced level for edge detection.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) level_d <= 1'b0;
    else     level_d <= level;
  end

  assign press = level & ~level_d;

endmodule

// File: rtl/digit_entry.sv
// Four-digit BCD plus sign entry controller driven by five push-buttons.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// EDIT     | buttons edit the digit/sign under the cursor or move it
// WAIT_ACK | guess committed, GUESS_VALID high, edits frozen until ack
module digit_entry
  import digit_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            BTN_UP,
  input  logic            BTN_DOWN,
  input  logic            BTN_LEFT,
  input  logic            BTN_RIGHT,
  input  logic            BTN_ENTER,
  input  logic            GUESS_ACK,
  output logic [DB_W-1:0] databuffer,
  output logic [2:0]      i,
  output logic            GUESS_VALID
);

  logic [4:0]      btn_raw;
  logic [4:0]      btn_press;
  logic            p_enter, p_up, p_down, p_left, p_right;

  state_e          state, state_nxt;
  logic [DB_W-1:0] db_nxt;
  logic [2:0]      i_nxt;
  logic            gv_nxt;

  assign btn_raw = {BTN_ENTER, BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT};
  assign {p_enter, p_up, p_down, p_left, p_right} = btn_press;

  for (genvar b = 0; b < 5; b++) begin : g_btn
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .CLK   (CLK),
      .RST   (RST),
      .btn   (btn_raw[b]),
      .press (btn_press[b])
    );
  end

  // Next-state decode; the priority chain lets only one press act per cycle.
  always_comb begin
    state_nxt = state;
    db_nxt    = databuffer;
    i_nxt     = i;
    gv_nxt    = GUESS_VALID;
    case (state)
      EDIT: begin
        if (p_enter) begin
          gv_nxt    = 1'b1;
          state_nxt = WAIT_ACK;
        end else if (p_up) begin
          if (i == CURSOR_MAX) db_nxt[SIGN_BIT] = ~databuffer[SIGN_BIT];
          else begin
            for (int d = 0; d < DIGIT_N; d++)
              if (i == 3'(d))
                db_nxt[d*DIGIT_W +: DIGIT_W] = bcd_inc(databuffer[d*DIGIT_W +: DIGIT_W]);
          end
        end else if (p_down) begin
          if (i == CURSOR_MAX) db_nxt[SIGN_BIT] = ~databuffer[SIGN_BIT];
          else begin
            for (int d = 0; d < DIGIT_N; d++)
              if (i == 3'(d))
                db_nxt[d*DIGIT_W +: DIGIT_W] = bcd_dec(databuffer[d*DIGIT_W +: DIGIT_W]);
          end
        end else if (p_left) begin
          i_nxt = (i >= CURSOR_MAX) ? 3'd0 : i + 3'd1;
        end else if (p_right) begin
          i_nxt = (i == 3'd0 || i > CURSOR_MAX) ? CURSOR_MAX : i - 3'd1;
        end
      end
      WAIT_ACK: begin
        if (GUESS_ACK) begin
          gv_nxt    = 1'b0;
          state_nxt = EDIT;
        end
      end
      default: begin
        state_nxt = EDIT;
        gv_nxt    = 1'b0;
      end
    endcase
  end

  // State, entry buffer, cursor and handshake registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= EDIT;
      databuffer  <= '0;
      i           <= 3'd0;
      GUESS_VALID <= 1'b0;
    end else begin
      state       <= state_nxt;
      databuffer  <= db_nxt;
      i           <= i_nxt;
      GUESS_VALID <= gv_nxt;
    end
  end

endmodule
